// File: rtl/mpmc12_state_machine.sv
// Per-request sequencer for the mpmc12 memory controller: dispatches refresh, write,
// read and read-modify-write sequences to the DDR app interface with a hang timer.
module mpmc12_state_machine #(
  parameter int BURST_W    = 8,
  parameter int PRESET_CYC = 3,
  parameter int ALU_LAT    = 4,
  parameter int TO_CYCLES  = 1024,
  parameter bit REFRESH_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               calib_complete,
  input  logic               rst_busy,
  input  logic               ref_req,
  output logic               ref_ack,
  output logic               app_ref_req,
  input  logic               app_ref_ack,
  input  logic               req_v,
  input  logic               req_cyc,
  input  logic               req_we,
  input  logic               req_rmw,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [BURST_W-1:0] req_burst_cnt,
  input  logic [BURST_W-1:0] resp_burst_cnt,
  input  logic               rdy,
  input  logic               wdf_rdy,
  input  logic               rmw_hit,
  output logic [3:0]         state,
  output logic               select_next,
  output logic               timeout
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    REFRESH     = 4'd1,
    PRESET      = 4'd2,
    WRITE_DATA0 = 4'd3,
    WRITE_DATA1 = 4'd4,
    READ_DATA0  = 4'd5,
    READ_DATA1  = 4'd6,
    READ_DATA2  = 4'd7,
    ALU         = 4'd8,
    ALU_PIPE    = 4'd9,
    WRITE_TRAMP = 4'd10,
    WAIT_NACK   = 4'd11
  } state_t;

  localparam int TO_W   = $clog2(TO_CYCLES);
  localparam int PH_MAX = (PRESET_CYC > ALU_LAT) ? PRESET_CYC : ALU_LAT;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TO_CYCLES - 1);
  localparam logic [PH_W-1:0] PRESET_LAST = PH_W'(PRESET_CYC - 1);
  localparam logic [PH_W-1:0] ALU_LAST    = PH_W'(ALU_LAT - 1);

  state_t             state_reg, state_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic [PH_W-1:0]    ph_cnt_reg, ph_cnt_next;
  logic               timeout_reg, timeout_next;
  logic               ref_ack_reg, ref_ack_next;
  logic [BURST_W-1:0] rd_last;

  // Modular compare: an all-ones burst_len makes the final beat count wrap to 0.
  assign rd_last = burst_len + BURST_W'(1);

  always_comb begin
    state_next   = state_reg;
    ph_cnt_next  = '0;
    timeout_next = 1'b0;
    to_cnt_next  = '0;
    ref_ack_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (calib_complete && !rst_busy) begin
          if (REFRESH_EN && ref_req) state_next = REFRESH;
          else if (req_v)            state_next = PRESET;
        end
      end
      REFRESH:     if (app_ref_ack) state_next = IDLE;
      PRESET: begin
        if (ph_cnt_reg == PRESET_LAST) begin
          if (req_cyc && req_we) state_next = WRITE_DATA0;
          else if (req_cyc)      state_next = READ_DATA0;
          else                   state_next = IDLE;
        end else begin
          ph_cnt_next = ph_cnt_reg + PH_W'(1);
        end
      end
      WRITE_DATA0: state_next = WRITE_DATA1;
      WRITE_DATA1: if (wdf_rdy && rdy && req_burst_cnt == burst_len) state_next = IDLE;
      READ_DATA0:  if (rdy) state_next = (burst_len == '0) ? READ_DATA1 : READ_DATA2;
      READ_DATA1:  if (resp_burst_cnt == BURST_W'(1)) state_next = WAIT_NACK;
      READ_DATA2:  if (resp_burst_cnt == rd_last) state_next = req_rmw ? ALU : WAIT_NACK;
      ALU:         if (rmw_hit) state_next = ALU_PIPE;
      ALU_PIPE: begin
        if (ph_cnt_reg == ALU_LAST) state_next = WRITE_TRAMP;
        else                        ph_cnt_next = ph_cnt_reg + PH_W'(1);
      end
      WRITE_TRAMP: state_next = WRITE_DATA0;
      WAIT_NACK:   state_next = IDLE;
      default:     state_next = IDLE;
    endcase

    // Forced abort overrides whatever the sequence above decided.
    if (state_reg != IDLE && calib_complete && to_cnt_reg == TO_LAST) begin
      state_next   = IDLE;
      timeout_next = 1'b1;
      ph_cnt_next  = '0;
    end

    // Saturates so an abort fires as soon as calibration returns after a long stall.
    if (state_next != state_reg || state_reg == IDLE) to_cnt_next = '0;
    else if (to_cnt_reg != TO_LAST)                   to_cnt_next = to_cnt_reg + TO_W'(1);
    else                                              to_cnt_next = to_cnt_reg;

    ref_ack_next = REFRESH_EN && (state_next == REFRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      to_cnt_reg  <= '0;
      ph_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
      ref_ack_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      to_cnt_reg  <= to_cnt_next;
      ph_cnt_reg  <= ph_cnt_next;
      timeout_reg <= timeout_next;
      ref_ack_reg <= ref_ack_next;
    end
  end

  assign state       = state_reg;
  assign select_next = (state_reg == IDLE);
  assign timeout     = timeout_reg;
  assign ref_ack     = ref_ack_reg;
  assign app_ref_req = ref_ack_reg;

endmodule

// File: tb/tb_mpmc12_state_machine.sv
// Bench for mpmc12_state_machine: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a dwell-time behavioural model.
module tb_mpmc12_state_machine;
  localparam int PRESET_CYC = 3;
  localparam int ALU_LAT    = 4;
  localparam int TO_CYCLES  = 1024;

  localparam int S_IDLE = 0, S_REF = 1, S_PRE = 2, S_WD0 = 3, S_WD1 = 4, S_RD0 = 5,
                 S_RD1 = 6, S_RD2 = 7, S_ALU = 8, S_PIPE = 9, S_TRAMP = 10, S_NACK = 11;

  logic clk = 1'b0, rst = 1'b1;
  logic calib_complete = 1'b0, rst_busy = 1'b0, ref_req = 1'b0, app_ref_ack = 1'b0;
  logic req_v = 1'b0, req_cyc = 1'b0, req_we = 1'b0, req_rmw = 1'b0;
  logic rdy = 1'b0, wdf_rdy = 1'b0, rmw_hit = 1'b0;
  logic [7:0] burst_len = '0, req_burst_cnt = '0, resp_burst_cnt = '0;
  logic ref_ack, app_ref_req, select_next, timeout;
  logic [3:0] state;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mpmc12_state_machine dut (
    .clk(clk), .rst(rst), .calib_complete(calib_complete), .rst_busy(rst_busy),
    .ref_req(ref_req), .ref_ack(ref_ack), .app_ref_req(app_ref_req),
    .app_ref_ack(app_ref_ack), .req_v(req_v), .req_cyc(req_cyc), .req_we(req_we),
    .req_rmw(req_rmw), .burst_len(burst_len), .req_burst_cnt(req_burst_cnt),
    .resp_burst_cnt(resp_burst_cnt), .rdy(rdy), .wdf_rdy(wdf_rdy), .rmw_hit(rmw_hit),
    .state(state), .select_next(select_next), .timeout(timeout)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: one unbounded dwell counter per visit drives both the fixed
  // PRESET/ALU_PIPE lengths and the hang abort (dwell reaches TO_CYCLES-1 with calib).
  int m_state = S_IDLE, m_dwell = 0;
  bit m_to = 1'b0;

  always @(posedge clk) begin : model
    int ns;
    bit to;
    logic [7:0] last;
    ns   = m_state;
    to   = 1'b0;
    last = burst_len + 8'd1;
    if (rst) ns = S_IDLE;
    else if (m_state != S_IDLE && calib_complete && m_dwell >= TO_CYCLES - 1) begin
      ns = S_IDLE;
      to = 1'b1;
    end else begin
      case (m_state)
        S_IDLE:  if (calib_complete && !rst_busy) ns = ref_req ? S_REF : (req_v ? S_PRE : S_IDLE);
        S_REF:   if (app_ref_ack) ns = S_IDLE;
        S_PRE:   if (m_dwell == PRESET_CYC - 1) ns = !req_cyc ? S_IDLE : (req_we ? S_WD0 : S_RD0);
        S_WD0:   ns = S_WD1;
        S_WD1:   if (wdf_rdy && rdy && req_burst_cnt == burst_len) ns = S_IDLE;
        S_RD0:   if (rdy) ns = (burst_len == 8'd0) ? S_RD1 : S_RD2;
        S_RD1:   if (resp_burst_cnt == 8'd1) ns = S_NACK;
        S_RD2:   if (resp_burst_cnt == last) ns = req_rmw ? S_ALU : S_NACK;
        S_ALU:   if (rmw_hit) ns = S_PIPE;
        S_PIPE:  if (m_dwell == ALU_LAT - 1) ns = S_TRAMP;
        S_TRAMP: ns = S_WD0;
        S_NACK:  ns = S_IDLE;
        default: ns = S_IDLE;
      endcase
    end
    m_dwell <= (rst || ns != m_state || ns == S_IDLE) ? 0 : m_dwell + 1;
    m_state <= ns;
    m_to    <= to;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", int'(state), m_state);
      check("select_next", int'(select_next), int'(m_state == S_IDLE));
      check("timeout", int'(timeout), int'(m_to));
      check("ref_ack", int'(ref_ack), int'(m_state == S_REF));
      check("app_ref_req", int'(app_ref_req), int'(m_state == S_REF));
    end
  end

  initial begin
    tick(2);
    chk_en = 1'b1;
    check("reset_state", int'(state), 0);
    check("reset_select_next", int'(select_next), 1);
    check("reset_ref_ack", int'(ref_ack), 0);
    check("reset_timeout", int'(timeout), 0);
    rst = 1'b0;

    // Refresh wins over a pending request, then the request dispatches.
    calib_complete = 1'b1; ref_req = 1'b1; req_v = 1'b1; req_cyc = 1'b1; req_we = 1'b1;
    burst_len = 8'd3;
    tick(1);
    check("refresh_enter", int'(state), 1);
    check("refresh_ref_ack", int'(ref_ack), 1);
    check("refresh_app_ref_req", int'(app_ref_req), 1);
    ref_req = 1'b0;
    tick(4);
    app_ref_ack = 1'b1;
    tick(1);
    check("refresh_exit", int'(state), 0);
    check("refresh_ack_clear", int'(ref_ack), 0);
    app_ref_ack = 1'b0;
    $display("[%0t] refresh transaction done", $time);

    // Write burst_len=3.
    tick(1);
    check("wr_preset", int'(state), 2);
    req_v = 1'b0;
    tick(2);
    check("wr_preset_cyc3", int'(state), 2);
    tick(1);
    check("wr_wd0", int'(state), 3);
    check("wr_select_busy", int'(select_next), 0);
    tick(1);
    check("wr_wd1", int'(state), 4);
    rdy = 1'b1; wdf_rdy = 1'b1; req_burst_cnt = 8'd2;
    tick(1);
    check("wr_wd1_hold", int'(state), 4);
    req_burst_cnt = 8'd3;
    tick(1);
    check("wr_done", int'(state), 0);
    check("wr_select_idle", int'(select_next), 1);
    rdy = 1'b0; wdf_rdy = 1'b0; req_burst_cnt = 8'd0;
    $display("[%0t] write transaction done", $time);

    // Read burst_len=0.
    req_v = 1'b1; req_we = 1'b0; burst_len = 8'd0;
    tick(1);
    req_v = 1'b0;
    tick(3);
    check("rd_rd0", int'(state), 5);
    tick(2);
    check("rd_rd0_wait", int'(state), 5);
    rdy = 1'b1;
    tick(1);
    check("rd_rd1", int'(state), 6);
    rdy = 1'b0;
    tick(1);
    check("rd_rd1_hold", int'(state), 6);
    resp_burst_cnt = 8'd1;
    tick(1);
    check("rd_nack", int'(state), 11);
    resp_burst_cnt = 8'd0;
    tick(1);
    check("rd_idle", int'(state), 0);
    $display("[%0t] read transaction done", $time);

    // RMW burst_len=1.
    req_v = 1'b1; req_rmw = 1'b1; burst_len = 8'd1;
    tick(1);
    req_v = 1'b0;
    tick(3);
    rdy = 1'b1;
    tick(1);
    check("rmw_rd2", int'(state), 7);
    rdy = 1'b0; resp_burst_cnt = 8'd1;
    tick(1);
    check("rmw_rd2_hold", int'(state), 7);
    resp_burst_cnt = 8'd2;
    tick(1);
    check("rmw_alu", int'(state), 8);
    resp_burst_cnt = 8'd0;
    tick(2);
    check("rmw_alu_wait", int'(state), 8);
    rmw_hit = 1'b1;
    tick(1);
    check("rmw_pipe", int'(state), 9);
    rmw_hit = 1'b0;
    tick(3);
    check("rmw_pipe_cyc4", int'(state), 9);
    tick(1);
    check("rmw_tramp", int'(state), 10);
    tick(1);
    check("rmw_wd0", int'(state), 3);
    rdy = 1'b1; wdf_rdy = 1'b1; req_burst_cnt = 8'd1;
    tick(2);
    check("rmw_done", int'(state), 0);
    rdy = 1'b0; wdf_rdy = 1'b0; req_burst_cnt = 8'd0; req_rmw = 1'b0;
    $display("[%0t] rmw transaction done", $time);

    // burst_len all-ones: READ_DATA2 leaves only on resp_burst_cnt wrapping to 0.
    req_v = 1'b1; burst_len = 8'hFF; resp_burst_cnt = 8'd0;
    tick(1);
    req_v = 1'b0;
    tick(3);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0; resp_burst_cnt = 8'd5;
    check("wrap_rd2", int'(state), 7);
    tick(1);
    check("wrap_rd2_hold", int'(state), 7);
    resp_burst_cnt = 8'd0;
    tick(1);
    check("wrap_nack", int'(state), 11);
    tick(1);
    $display("[%0t] wrap transaction done", $time);

    // Hang in READ_DATA0 with calibration up: forced abort after TO_CYCLES cycles.
    req_v = 1'b1; burst_len = 8'd0;
    tick(1);
    req_v = 1'b0;
    tick(3);
    check("hang_rd0", int'(state), 5);
    tick(TO_CYCLES - 1);
    check("hang_still", int'(state), 5);
    check("hang_no_to", int'(timeout), 0);
    tick(1);
    check("hang_abort", int'(state), 0);
    check("hang_timeout", int'(timeout), 1);
    tick(1);
    check("hang_pulse_end", int'(timeout), 0);
    $display("[%0t] hang abort transaction done", $time);

    // Same hang with calibration down: no abort.
    req_v = 1'b1;
    tick(1);
    req_v = 1'b0;
    tick(3);
    calib_complete = 1'b0;
    tick(TO_CYCLES + 20);
    check("nocal_still", int'(state), 5);
    check("nocal_no_to", int'(timeout), 0);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0; resp_burst_cnt = 8'd1;
    tick(2);
    check("nocal_idle", int'(state), 0);
    resp_burst_cnt = 8'd0; calib_complete = 1'b1;
    $display("[%0t] hang no-calib transaction done", $time);

    // Reset mid ALU_PIPE.
    req_v = 1'b1; req_rmw = 1'b1; burst_len = 8'd1;
    tick(1);
    req_v = 1'b0;
    tick(3);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0; resp_burst_cnt = 8'd2;
    tick(1);
    resp_burst_cnt = 8'd0; rmw_hit = 1'b1;
    tick(1);
    rmw_hit = 1'b0;
    check("rst_pipe", int'(state), 9);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("rst_state", int'(state), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_ref_ack", int'(ref_ack), 0);
    check("rst_app_ref_req", int'(app_ref_req), 0);
    rst = 1'b0; req_rmw = 1'b0;
    $display("[%0t] reset transaction done", $time);

    // Randomized traffic, compared every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      int bsel;
      rst            = ($urandom_range(0, 199) == 0);
      calib_complete = ($urandom_range(0, 19) != 0);
      rst_busy       = ($urandom_range(0, 15) == 0);
      ref_req        = ($urandom_range(0, 7) == 0);
      app_ref_ack    = ($urandom_range(0, 3) == 0);
      req_v          = $urandom_range(0, 1);
      req_cyc        = ($urandom_range(0, 5) != 0);
      req_we         = $urandom_range(0, 1);
      req_rmw        = $urandom_range(0, 1);
      rdy            = $urandom_range(0, 1);
      wdf_rdy        = $urandom_range(0, 1);
      rmw_hit        = ($urandom_range(0, 3) == 0);
      bsel           = $urandom_range(0, 4);
      burst_len      = (bsel == 4) ? 8'hFF : 8'(bsel);
      req_burst_cnt  = 8'($urandom_range(0, 3));
      resp_burst_cnt = 8'($urandom_range(0, 4));
      tick(1);
    end
    $display("[%0t] random traffic done", $time);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
